// File: rtl/hazard_unit.sv
// ============================================================================
// hazard_unit: pipeline valid tracking, load-use stall, branch flush, EX forwarding.
// Optional perf counters: define HAZARD_PERF_CNT_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_unit #(
  parameter int REG_W          = 3,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [REG_W-1:0] ifid_reg1_i,
  input  logic [REG_W-1:0] ifid_reg2_i,
  input  logic [REG_W-1:0] idex_reg1_i,
  input  logic [REG_W-1:0] idex_reg2_i,
  input  logic [REG_W-1:0] idex_regD_i,
  input  logic             idex_read_mem_i,
  input  logic             idex_write_reg_i,
  input  logic [REG_W-1:0] exmem_regD_i,
  input  logic             exmem_write_reg_i,
  input  logic [REG_W-1:0] memwb_regD_i,
  input  logic             memwb_write_reg_i,
  input  logic             branch_taken_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             idex_bubble_o,
  output logic             flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [3:0]       stage_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // FLUSH covers the cycles after the branch cycle itself, so load penalty-2.
  localparam int          PEN_LOAD_I = (BRANCH_PENALTY > 1) ? BRANCH_PENALTY - 2 : 0;
  localparam logic [1:0]  PEN_LOAD   = PEN_LOAD_I[1:0];

  state_t     state;
  logic [3:0] valid;
  logic [1:0] pen_cnt;
  logic       load_use;
  logic       branch;
  logic       flush;
  logic       stall;

  assign load_use = valid[0] & valid[1] & idex_read_mem_i & idex_write_reg_i &
                    ((idex_regD_i == ifid_reg1_i) | (idex_regD_i == ifid_reg2_i));
  assign branch   = valid[1] & branch_taken_i;
  assign flush    = branch | (state == FLUSH);
  assign stall    = load_use & ~flush;

  assign pc_stall_o    = stall;
  assign ifid_stall_o  = stall;
  assign idex_bubble_o = stall;
  assign flush_o       = flush;
  assign stage_valid_o = valid;

  always_comb begin
    fwd_a_o = 2'b00;
    if (valid[2] && exmem_write_reg_i && (exmem_regD_i == idex_reg1_i))
      fwd_a_o = 2'b01;
    else if (valid[3] && memwb_write_reg_i && (memwb_regD_i == idex_reg1_i))
      fwd_a_o = 2'b10;
  end

  always_comb begin
    fwd_b_o = 2'b00;
    if (valid[2] && exmem_write_reg_i && (exmem_regD_i == idex_reg2_i))
      fwd_b_o = 2'b01;
    else if (valid[3] && memwb_write_reg_i && (memwb_regD_i == idex_reg2_i))
      fwd_b_o = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid   <= 4'b0000;
      pen_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          valid <= {valid[2:0], 1'b0};
          if (start_i) state <= RUN;
        end
        default: begin
          if (start_i) begin
            state   <= RUN;
            valid   <= 4'b0000;
            pen_cnt <= 2'd0;
          end else begin
            valid <= {valid[2], valid[1], valid[0] & ~stall & ~flush,
                      flush ? 1'b0 : (stall ? valid[0] : 1'b1)};
            if (state == RUN) begin
              if (branch && (BRANCH_PENALTY > 1)) begin
                state   <= FLUSH;
                pen_cnt <= PEN_LOAD;
              end
            end else if (pen_cnt == 2'd0) begin
              state <= RUN;
            end else begin
              pen_cnt <= pen_cnt - 2'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating event counters; a branch counts once, not per FLUSH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (start_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (branch && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

`default_nettype wire
